radix_seq_add: RTL

- Multi-cycle wide adder/subtractor controller. It time-shares one 16-bit combinational adder slice across WORDS slices of a 16*WORDS-bit operand, one slice per clock, least-significant slice first.
- Owns operand capture, the carry register between slices, the slice index counter, subtract conditioning, signed-overflow detection and the start/done handshake.
- Sits between a requesting datapath (accumulator/ALU sequencer) and the shared 16-bit adder.

---
 rtl/radix_seq_add_pkg.sv | 20 ++
 rtl/radix_seq_add_if.sv | 41 ++++
 rtl/radix_seq_add_slice_add16.sv | 26 ++
 rtl/radix_seq_add.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/radix_seq_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : radix_seq_add_pkg
//  Description : Shared constants for the sequential wide adder/subtractor.
//                Holds the controller state encoding and the slice width.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package radix_seq_add_pkg;

  // Width of the shared combinational adder slice.
  localparam int SLICE_W = 16;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : radix_seq_add_pkg
`default_nettype wire

// File: rtl/radix_seq_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : radix_seq_add_if
//  Description : Request/response bundle between a requesting datapath
//                (master) and the sequential wide adder (slave).
//  Signals     : start_i/abort_i/sub_i/cin_i/a_i/b_i  request side
//                ready_o/busy_o/done_o/sum_o/cout_o/ovf_o  response side
//  Revision    : 1.0  initial release
// ============================================================================
interface radix_seq_add_if #(
  parameter int WORDS = 4
);
  import radix_seq_add_pkg::*;

  localparam int OP_W = SLICE_W * WORDS;

  logic            start_i;
  logic            abort_i;
  logic            sub_i;
  logic            cin_i;
  logic [OP_W-1:0] a_i;
  logic [OP_W-1:0] b_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [OP_W-1:0] sum_o;
  logic            cout_o;
  logic            ovf_o;

  modport master (
    output start_i, abort_i, sub_i, cin_i, a_i, b_i,
    input  ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
  );

  modport slave (
    input  start_i, abort_i, sub_i, cin_i, a_i, b_i,
    output ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
  );

endinterface : radix_seq_add_if
`default_nettype wire

// File: rtl/radix_seq_add_slice_add16.sv
`default_nettype none
// ============================================================================
//  Module      : slice_add16
//  Description : Purely combinational 16-bit adder slice, {cout,sum} =
//                a + b + cin. Any 16-bit adder with this interface (e.g. a
//                carry-skip implementation) may replace the body.
//  Ports       : a, b  slice operands
//                cin   carry in
//                sum   slice sum
//                cout  carry out
//  Revision    : 1.0  initial release
// ============================================================================
module slice_add16
  import radix_seq_add_pkg::*;
(
  input  wire logic [SLICE_W-1:0] a,
  input  wire logic [SLICE_W-1:0] b,
  input  wire logic               cin,
  output logic      [SLICE_W-1:0] sum,
  output logic                    cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule : slice_add16
`default_nettype wire

// File: rtl/radix_seq_add.sv
`default_nettype none
// ============================================================================
//  Module      : radix_seq_add
//  Description : Multi-cycle wide adder/subtractor. One 16-bit adder slice is
//                reused for WORDS slices, least-significant slice first, one
//                slice per clock. Handles operand capture, inter-slice carry,
//                subtract conditioning, signed overflow and start/done.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    radix_seq_add_if slave modport (request/response)
//  Revision    : 1.0  initial release
// ============================================================================
module radix_seq_add
  import radix_seq_add_pkg::*;
#(
  parameter int WORDS = 4
)(
  input  wire logic       clk,
  input  wire logic       rst_n,
  radix_seq_add_if.slave  bus
);

  localparam int               OP_W  = SLICE_W * WORDS;
  localparam int               IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORDS - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_index;
  logic             r_carry;
  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;        // holds B already inverted for subtract
  logic [OP_W-1:0]  r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_ready;
  logic             w_busy;
  logic             w_done;

  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_s_slice;
  logic               w_c_slice;

  // Start is only honoured outside RUN; a start during RUN is dropped.
  assign w_accept = bus.start_i && (r_state != ST_RUN);
  // A slice is computed on every RUN edge unless the operation is aborted.
  assign w_step   = (r_state == ST_RUN) && !bus.abort_i;
  assign w_last   = (r_index == C_LAST_IDX);

  assign w_a_slice = r_a[int'(r_index) * SLICE_W +: SLICE_W];
  assign w_b_slice = r_b[int'(r_index) * SLICE_W +: SLICE_W];

  // The single shared adder slice.
  slice_add16 u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_s_slice),
    .cout (w_c_slice)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort_i)  w_state_nxt = ST_IDLE;
        else if (w_last)  w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A start here chains straight into the next operation.
        if (bus.start_i) w_state_nxt = ST_RUN;
        else             w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b1;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
      end
      ST_DONE: begin
        w_done  = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture and slice accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_index <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract as a + ~b + 1; cin_i acts as an active-high borrow, so the
      // effective carry-in is inverted relative to the add case.
      r_a     <= bus.a_i;
      r_b     <= bus.sub_i ? ~bus.b_i : bus.b_i;
      r_carry <= bus.cin_i ^ bus.sub_i;
      r_index <= '0;
    end else if (w_step) begin
      r_sum[int'(r_index) * SLICE_W +: SLICE_W] <= w_s_slice;
      r_carry <= w_c_slice;
      r_index <= r_index + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_c_slice;
        // Overflow: operands agree in sign but the result sign differs.
        r_ovf  <= (r_a[OP_W-1] == r_b[OP_W-1]) &&
                  (w_s_slice[SLICE_W-1] != r_a[OP_W-1]);
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.busy_o  = w_busy;
  assign bus.done_o  = w_done;
  assign bus.sum_o   = r_sum;
  assign bus.cout_o  = r_cout;
  assign bus.ovf_o   = r_ovf;

endmodule : radix_seq_add
`default_nettype wire
